// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder/subtractor.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of DIGIT-wide slices needed to cover one operand.
  function automatic int calc_nslice(input int width, input int digit);
    return width / digit;
  endfunction

  // The slice counter holds 0..NSLICE-1, so it never needs to be narrower than one bit.
  function automatic int cnt_width(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_unit_fa_chain.sv
// Combinational DIGIT-bit ripple of 1-bit full adders; also exposes the carry into
// the top bit so the caller can form two's-complement overflow.
module fa_chain #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             c_in,
  output logic [DIGIT-1:0] s_d,
  output logic             c_out,
  output logic             c_msb_in
);

  logic [DIGIT:0] c;

  assign c[0] = c_in;

  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
    assign s_d[gi]   = a_d[gi] ^ b_d[gi] ^ c[gi];
    assign c[gi + 1] = (a_d[gi] & b_d[gi]) | (c[gi] & (a_d[gi] ^ b_d[gi]));
  end

  assign c_out    = c[DIGIT];
  assign c_msb_in = c[DIGIT - 1];

endmodule

// File: rtl/serial_adder_unit.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock, carry held in a register
// between slices, valid/ready handshakes on both the operand and result sides.
module serial_adder_unit
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NSLICE = calc_nslice(WIDTH, DIGIT);
  localparam int CW     = cnt_width(NSLICE);
  localparam logic [CW-1:0] CNT_LOAD = CW'(NSLICE - 1);

  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_check
    $error("serial_adder_unit: DIGIT must divide WIDTH and WIDTH must be at least 2");
  end

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  a_sh_reg, b_sh_reg, sum_reg;
  logic [CW-1:0]     cnt_reg;
  logic              carry_reg, cout_reg, ovf_reg;

  logic [DIGIT-1:0]  s_d;
  logic              c_out, c_msb_in;
  logic [WIDTH-1:0]  sum_shift;

  fa_chain #(.DIGIT(DIGIT)) u_fa_chain (
    .a_d      (a_sh_reg[DIGIT-1:0]),
    .b_d      (b_sh_reg[DIGIT-1:0]),
    .c_in     (carry_reg),
    .s_d      (s_d),
    .c_out    (c_out),
    .c_msb_in (c_msb_in)
  );

  // New digits enter at the top, so after NSLICE shifts the first digit sits at bit 0.
  if (DIGIT == WIDTH) begin : g_sum_full
    assign sum_shift = s_d;
  end else begin : g_sum_part
    assign sum_shift = {s_d, sum_reg[WIDTH-1:DIGIT]};
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (cnt_reg == '0) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      sum_reg   <= '0;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          // Subtraction is a + ~b + ~cin, so the borrow-in is folded into the carry.
          if (in_valid) begin
            a_sh_reg  <= a;
            b_sh_reg  <= sub ? ~b : b;
            carry_reg <= sub ? ~cin : cin;
            cnt_reg   <= CNT_LOAD;
          end
        end
        RUN: begin
          sum_reg   <= sum_shift;
          a_sh_reg  <= a_sh_reg >> DIGIT;
          b_sh_reg  <= b_sh_reg >> DIGIT;
          carry_reg <= c_out;
          cnt_reg   <= cnt_reg - CW'(1);
          if (cnt_reg == '0) begin
            cout_reg <= c_out;
            ovf_reg  <= c_msb_in ^ c_out;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_serial_adder_unit.sv
// Bench for serial_adder_unit: three instances (DIGIT=1, 4, 2 at WIDTH=8) checked
// against an arithmetic reference model.
module tb_serial_adder_unit;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid [3];
  logic         in_ready [3];
  logic [W-1:0] a [3];
  logic [W-1:0] b [3];
  logic         cin [3];
  logic         sub [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [W-1:0] sum [3];
  logic         cout [3];
  logic         ovf [3];
  logic         busy [3];

  int checks = 0;
  int errors = 0;

  serial_adder_unit #(.WIDTH(W), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0]), .b(b[0]), .cin(cin[0]), .sub(sub[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .sum(sum[0]), .cout(cout[0]), .ovf(ovf[0]), .busy(busy[0])
  );

  serial_adder_unit #(.WIDTH(W), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1]), .b(b[1]), .cin(cin[1]), .sub(sub[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .sum(sum[1]), .cout(cout[1]), .ovf(ovf[1]), .busy(busy[1])
  );

  serial_adder_unit #(.WIDTH(W), .DIGIT(2)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a[2]), .b(b[2]), .cin(cin[2]), .sub(sub[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .sum(sum[2]), .cout(cout[2]), .ovf(ovf[2]), .busy(busy[2])
  );

  // Reference: plain integer arithmetic, result packed as {cout, ovf, sum}.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic sb);
    int ux, uy, sx, sy, r, c;
    logic co, ov;
    logic [W-1:0] s;
    ux = int'(x);
    uy = int'(y);
    c  = ci ? 1 : 0;
    sx = (ux >= (1 << (W - 1))) ? ux - (1 << W) : ux;
    sy = (uy >= (1 << (W - 1))) ? uy - (1 << W) : uy;
    if (!sb) begin
      s  = W'(ux + uy + c);
      co = (ux + uy + c) >= (1 << W);
      r  = sx + sy + c;
    end else begin
      s  = W'(ux - uy - c);
      co = ux >= (uy + c);
      r  = sx - sy - c;
    end
    ov = (r < -(1 << (W - 1))) || (r > (1 << (W - 1)) - 1);
    return {co, ov, s};
  endfunction

  // Drives one operation on instance k and waits for out_valid (lat = -1 on timeout).
  task automatic run_op(input int k, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic sb,
                        output int lat, output logic [W+1:0] res);
    for (int n = 0; n < 64 && !in_ready[k]; n++) begin
      @(posedge clk); #1;
    end
    a[k] = x; b[k] = y; cin[k] = ci; sub[k] = sb; in_valid[k] = 1'b1;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    a[k] = W'($urandom); b[k] = W'($urandom);
    cin[k] = 1'($urandom); sub[k] = 1'($urandom);
    lat = -1;
    for (int n = 1; n <= 64; n++) begin
      @(posedge clk); #1;
      if (out_valid[k]) begin
        lat = n;
        break;
      end
    end
    res = {cout[k], ovf[k], sum[k]};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b1; out_ready[k] = 1'b1;
      a[k] = W'($urandom); b[k] = W'($urandom); cin[k] = 1'b1; sub[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({out_valid[k], busy[k], in_ready[k], cout[k], ovf[k], sum[k]} !== {5'b00100, {W{1'b0}}}) begin
        errors++;
        $display("FAIL reset_state dut%0d got ov=%b busy=%b ir=%b cout=%b ovf=%b sum=%h want 0 0 1 0 0 00",
                 k, out_valid[k], busy[k], in_ready[k], cout[k], ovf[k], sum[k]);
      end
      in_valid[k] = 1'b0;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (busy[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_capture dut%0d busy got %b want 0", k, busy[k]);
      end
    end
  endtask

  task automatic test_add_d1();
    int lat;
    logic [W+1:0] res, exp;
    logic [W-1:0] x, y;
    logic ci;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin x = 8'h5A; y = 8'h33; ci = 1'b0; end
      else begin x = W'($urandom); y = W'($urandom); ci = 1'($urandom); end
      exp = model(x, y, ci, 1'b0);
      if (i == 0) exp = {1'b0, 1'b1, 8'h8D};
      run_op(0, x, y, ci, 1'b0, lat, res);
      checks++;
      if (lat !== 8) begin
        errors++;
        $display("FAIL add_d1_latency op%0d got %0d want 8", i, lat);
      end
      checks++;
      if (res !== exp) begin
        errors++;
        $display("FAIL add_d1_result op%0d a=%h b=%h cin=%b got %h want %h", i, x, y, ci, res, exp);
      end
    end
  endtask

  task automatic test_sub_d1();
    int lat;
    logic [W+1:0] res, exp;
    logic [W-1:0] x, y;
    logic ci;
    for (int i = 0; i < 7; i++) begin
      if (i == 0) begin x = 8'h10; y = 8'h20; ci = 1'b0; end
      else if (i == 1) begin x = 8'h80; y = 8'h01; ci = 1'b0; end
      else begin x = W'($urandom); y = W'($urandom); ci = 1'($urandom); end
      exp = model(x, y, ci, 1'b1);
      if (i == 0) exp = {1'b0, 1'b0, 8'hF0};
      if (i == 1) exp = {1'b1, 1'b1, 8'h7F};
      run_op(0, x, y, ci, 1'b1, lat, res);
      checks++;
      if (res !== exp || lat !== 8) begin
        errors++;
        $display("FAIL sub_d1 op%0d a=%h b=%h cin=%b got %h lat %0d want %h lat 8",
                 i, x, y, ci, res, lat, exp);
      end
    end
  endtask

  task automatic test_digit4();
    int lat;
    logic [W+1:0] res, exp;
    logic [W-1:0] x, y;
    logic ci, sb;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin x = 8'hFF; y = 8'h01; ci = 1'b1; sb = 1'b0; end
      else begin x = W'($urandom); y = W'($urandom); ci = 1'($urandom); sb = 1'($urandom); end
      exp = model(x, y, ci, sb);
      if (i == 0) exp = {1'b1, 1'b0, 8'h01};
      run_op(1, x, y, ci, sb, lat, res);
      checks++;
      if (lat !== 2) begin
        errors++;
        $display("FAIL digit4_latency op%0d got %0d want 2", i, lat);
      end
      checks++;
      if (res !== exp) begin
        errors++;
        $display("FAIL digit4_result op%0d a=%h b=%h cin=%b sub=%b got %h want %h",
                 i, x, y, ci, sb, res, exp);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [W+1:0] res, exp, held;
    logic [W-1:0] x, y;
    x = W'($urandom); y = W'($urandom);
    exp = model(x, y, 1'b0, 1'b0);
    out_ready[0] = 1'b0;
    run_op(0, x, y, 1'b0, 1'b0, lat, res);
    checks++;
    if (res !== exp) begin
      errors++;
      $display("FAIL backpressure_result got %h want %h", res, exp);
    end
    held = exp;
    for (int c = 0; c < 5; c++) begin
      in_valid[0] = 1'b1; a[0] = W'($urandom); b[0] = W'($urandom); sub[0] = 1'($urandom);
      @(posedge clk); #1;
      checks++;
      if ({cout[0], ovf[0], sum[0]} !== held || in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1) begin
        errors++;
        $display("FAIL backpressure_hold cyc%0d got res=%h ir=%b ov=%b want res=%h ir=0 ov=1",
                 c, {cout[0], ovf[0], sum[0]}, in_ready[0], out_valid[0], held);
      end
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release got ov=%b ir=%b want ov=0 ir=1", out_valid[0], in_ready[0]);
    end
    x = W'($urandom); y = W'($urandom);
    exp = model(x, y, 1'b1, 1'b1);
    run_op(0, x, y, 1'b1, 1'b1, lat, res);
    checks++;
    if (res !== exp || lat !== 8) begin
      errors++;
      $display("FAIL backpressure_next got %h lat %0d want %h lat 8", res, lat, exp);
    end
  endtask

  task automatic test_reset_midrun();
    int lat;
    logic [W+1:0] res;
    for (int n = 0; n < 64 && !in_ready[0]; n++) begin
      @(posedge clk); #1;
    end
    a[0] = 8'h5A; b[0] = 8'h33; cin[0] = 1'b0; sub[0] = 1'b0; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || sum[0] !== 8'h00) begin
      errors++;
      $display("FAIL reset_midrun got ov=%b busy=%b sum=%h want 0 0 00", out_valid[0], busy[0], sum[0]);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(0, 8'h5A, 8'h33, 1'b0, 1'b0, lat, res);
    checks++;
    if (res !== {1'b0, 1'b1, 8'h8D} || lat !== 8) begin
      errors++;
      $display("FAIL reset_reissue got %h lat %0d want 18d lat 8", res, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] xs [3];
    logic [W-1:0] ys [3];
    logic         cs [3];
    logic         ss [3];
    int           acc [3];
    int           nacc, got, e;
    logic         rdy;
    logic [W+1:0] exp;
    for (int i = 0; i < 3; i++) begin
      xs[i] = W'($urandom); ys[i] = W'($urandom); cs[i] = 1'($urandom); ss[i] = 1'($urandom);
      acc[i] = 0;
    end
    for (int n = 0; n < 64 && !in_ready[2]; n++) begin
      @(posedge clk); #1;
    end
    out_ready[2] = 1'b1;
    a[2] = xs[0]; b[2] = ys[0]; cin[2] = cs[0]; sub[2] = ss[0]; in_valid[2] = 1'b1;
    nacc = 0; got = 0; e = 0;
    while (got < 3 && e < 200) begin
      rdy = in_ready[2];
      @(posedge clk);
      e++;
      if (rdy && in_valid[2] && nacc < 3) begin
        acc[nacc] = e;
        nacc++;
      end
      #1;
      if (out_valid[2]) begin
        exp = model(xs[got], ys[got], cs[got], ss[got]);
        checks++;
        if ({cout[2], ovf[2], sum[2]} !== exp || (e - acc[got]) !== 4) begin
          errors++;
          $display("FAIL b2b_result op%0d got %h lat %0d want %h lat 4",
                   got, {cout[2], ovf[2], sum[2]}, e - acc[got], exp);
        end
        got++;
      end
      if (nacc < 3) begin
        a[2] = xs[nacc]; b[2] = ys[nacc]; cin[2] = cs[nacc]; sub[2] = ss[nacc];
      end else begin
        in_valid[2] = 1'b0;
      end
    end
    in_valid[2] = 1'b0;
    checks++;
    if (got !== 3 || nacc !== 3) begin
      errors++;
      $display("FAIL b2b_count got results=%0d accepts=%0d want 3 3", got, nacc);
    end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (acc[i] - acc[i-1] !== 6) begin
        errors++;
        $display("FAIL b2b_spacing op%0d got %0d want 6", i, acc[i] - acc[i-1]);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add_d1();
    test_sub_d1();
    test_digit4();
    test_backpressure();
    test_reset_midrun();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
